rf_stack_banked: RTL and testbench



---
 rtl/rf_stack_banked.sv | 110 +++++++++++
 tb/tb_rf_stack_banked.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rf_stack_banked.sv
// Banked integer register file: one private bank per preemption level, with
// sp (x2) shared through bank 0 and ra (x1) injection at interrupt entry.

module rf_stack_bank #(
  parameter int DataWidth = 32,
  parameter int NumRegs   = 32,
  parameter bit HoldsSp   = 1'b0,
  localparam int IndexWidth = $clog2(NumRegs)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wrEn,
  input  logic [IndexWidth-1:0]                wrAddr,
  input  logic [DataWidth-1:0]                 wrData,
  input  logic                                 raEn,
  input  logic [DataWidth-1:0]                 raData,
  output logic [NumRegs-1:0][DataWidth-1:0]    q
);

  for (genvar r = 0; r < NumRegs; r++) begin : gReg
    if (r == 0 || (r == 2 && !HoldsSp)) begin : gConst
      // x0 is hardwired; x2 only has storage in the bank that owns sp
      assign q[r] = '0;
    end else begin : gStore
      // RA injection takes priority over a normal write to the same cell
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    q[r] <= '0;
        else if (r == 1 && raEn)                       q[r] <= raData;
        else if (wrEn && wrAddr == IndexWidth'(r))     q[r] <= wrData;
      end
    end
  end

endmodule

module rf_stack_banked #(
  parameter int DataWidth = 32,
  parameter int NumRegs   = 32,
  parameter int NumLevels = 8,
  localparam int IndexWidth  = $clog2(NumRegs),
  localparam int IndexLevels = $clog2(NumLevels)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IndexLevels-1:0] level,
  input  logic                   writeEn,
  input  logic [IndexWidth-1:0]  writeAddr,
  input  logic [DataWidth-1:0]   writeData,
  input  logic                   writeRaEn,
  input  logic [DataWidth-1:0]   writeRaData,
  input  logic [IndexWidth-1:0]  readAddr1,
  input  logic [IndexWidth-1:0]  readAddr2,
  output logic [DataWidth-1:0]   readData1,
  output logic [DataWidth-1:0]   readData2,
  output logic [DataWidth-1:0]   readRa
);

  localparam logic [IndexWidth-1:0] RegSp = IndexWidth'(2);
  localparam logic [IndexWidth-1:0] RegRa = IndexWidth'(1);

  logic [NumLevels-1:0][NumRegs-1:0][DataWidth-1:0] regs;
  logic [IndexLevels-1:0] wrBank, rdBank1, rdBank2;
  logic                   wrValid;

  // Resolve the bank of the normal write: on interrupt entry the retiring
  // instruction belongs to the preempted level (one below), and sp always
  // lives in bank 0.
  always_comb begin
    wrValid = writeEn && (writeAddr != '0);
    if (writeAddr == RegSp)             wrBank = '0;
    else if (writeRaEn && level != '0)  wrBank = level - 1'b1;
    else                                wrBank = level;
  end

  for (genvar b = 0; b < NumLevels; b++) begin : gBank
    rf_stack_bank #(
      .DataWidth (DataWidth),
      .NumRegs   (NumRegs),
      .HoldsSp   (b == 0)
    ) uBank (
      .clk    (clk),
      .reset  (reset),
      .wrEn   (wrValid && wrBank == IndexLevels'(b)),
      .wrAddr (writeAddr),
      .wrData (writeData),
      .raEn   (writeRaEn && level == IndexLevels'(b)),
      .raData (writeRaData),
      .q      (regs[b])
    );
  end

  // Read ports: private registers from the active bank, sp from bank 0,
  // with write-through when the pending write hits the same cell.
  always_comb begin
    rdBank1   = (readAddr1 == RegSp) ? '0 : level;
    rdBank2   = (readAddr2 == RegSp) ? '0 : level;
    readData1 = regs[rdBank1][readAddr1];
    readData2 = regs[rdBank2][readAddr2];
    if (wrValid && writeAddr == readAddr1 && wrBank == rdBank1) readData1 = writeData;
    if (wrValid && writeAddr == readAddr2 && wrBank == rdBank2) readData2 = writeData;
  end

  // ra of the current level; an injected value outranks a normal write
  always_comb begin
    if (writeRaEn)                                         readRa = writeRaData;
    else if (writeEn && writeAddr == RegRa && wrBank == level) readRa = writeData;
    else                                                   readRa = regs[level][RegRa];
  end

endmodule

// File: tb/tb_rf_stack_banked.sv
// Directed bench for rf_stack_banked: sp sharing, private banks, bypass,
// RA injection priority, x0 and asynchronous reset.

module tb_rf_stack_banked;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  level;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        writeRaEn;
  logic [31:0] writeRaData;
  logic [4:0]  readAddr1, readAddr2;
  logic [31:0] readData1, readData2, readRa;

  int nChecks = 0;
  int nFail   = 0;

  rf_stack_banked dut (
    .clk         (clk),
    .reset       (reset),
    .level       (level),
    .writeEn     (writeEn),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .writeRaEn   (writeRaEn),
    .writeRaData (writeRaData),
    .readAddr1   (readAddr1),
    .readAddr2   (readAddr2),
    .readData1   (readData1),
    .readData2   (readData2),
    .readRa      (readRa)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeEn = 1'b0; writeRaEn = 1'b0;
    writeAddr = '0; writeData = '0; writeRaData = '0;
  endtask

  initial begin
    reset = 1'b0; level = '0; readAddr1 = '0; readAddr2 = '0;
    idle();
    #12;
    readAddr1 = 5'd2; readAddr2 = 5'd3; #1;
    chk("reset_rd1", readData1, 32'h0);
    chk("reset_rd2", readData2, 32'h0);
    chk("reset_ra",  readRa,    32'h0);
    @(negedge clk); reset = 1'b1;

    // sp write from level 1 lands in bank 0
    @(negedge clk);
    level = 3'd1; writeEn = 1'b1; writeAddr = 5'd2; writeData = 32'h12345678;
    tick(); idle();
    readAddr1 = 5'd2; #1;
    chk("sp_lvl1", readData1, 32'h12345678);
    level = 3'd0; #1;
    chk("sp_lvl0", readData1, 32'h12345678);

    // private x3 at level 1
    @(negedge clk);
    level = 3'd1; writeEn = 1'b1; writeAddr = 5'd3; writeData = 32'h00001111;
    tick(); idle();
    readAddr1 = 5'd3; readAddr2 = 5'd2; #1;
    chk("x3_lvl1", readData1, 32'h00001111);
    chk("sp_keep", readData2, 32'h12345678);
    level = 3'd0; #1;
    chk("x3_lvl0", readData1, 32'h0);

    // write-through bypass at level 2, no edge
    @(negedge clk);
    level = 3'd2; writeEn = 1'b1; writeAddr = 5'd3; writeData = 32'h11110000;
    readAddr1 = 5'd3; readAddr2 = 5'd2; #1;
    chk("byp_rd1", readData1, 32'h11110000);
    chk("byp_rd2", readData2, 32'h12345678);
    // with RA entry the write targets bank 1, so no bypass into bank 2 reads
    writeRaEn = 1'b1; writeRaData = 32'h0; #1;
    chk("byp_bank", readData1, 32'h0);
    writeRaEn = 1'b0; writeEn = 1'b0; #1;
    chk("nobyp_rd1", readData1, 32'h0);
    chk("nobyp_rd2", readData2, 32'h12345678);

    // RA injection at level 2 together with a normal x1 write (goes to bank 1)
    @(negedge clk);
    level = 3'd2; writeRaEn = 1'b1; writeRaData = 32'heeeeffff;
    writeEn = 1'b1; writeAddr = 5'd1; writeData = 32'hffffeeee;
    readAddr1 = 5'd1; #1;
    chk("ra_bypass", readRa, 32'heeeeffff);
    chk("ra_rd1_nobyp", readData1, 32'h0);
    tick(); idle(); #1;
    chk("ra_lvl2", readRa, 32'heeeeffff);
    chk("x1_lvl2", readData1, 32'heeeeffff);
    level = 3'd1; #1;
    chk("ra_lvl1", readRa, 32'hffffeeee);
    level = 3'd0; #1;
    chk("ra_lvl0", readRa, 32'h0);

    // normal x1 write bypasses into readRa of the same level
    @(negedge clk);
    level = 3'd1; writeEn = 1'b1; writeAddr = 5'd1; writeData = 32'h0000abcd; #1;
    chk("ra_wr_byp", readRa, 32'h0000abcd);
    idle(); #1;
    chk("ra_wr_nocommit", readRa, 32'hffffeeee);

    // level 0 collision: RA injection wins over the normal x1 write
    @(negedge clk);
    level = 3'd0; writeRaEn = 1'b1; writeRaData = 32'h55555555;
    writeEn = 1'b1; writeAddr = 5'd1; writeData = 32'h66666666;
    tick(); idle(); #1;
    chk("ra_wins", readRa, 32'h55555555);

    // x0 ignores writes and never bypasses
    @(negedge clk);
    level = 3'd3; writeEn = 1'b1; writeAddr = 5'd0; writeData = 32'hdeadbeef;
    readAddr1 = 5'd0; readAddr2 = 5'd0; #1;
    chk("x0_nobyp", readData1, 32'h0);
    tick(); idle(); #1;
    chk("x0_stored", readData2, 32'h0);

    // asynchronous reset away from any edge
    @(negedge clk); #2;
    level = 3'd2; readAddr1 = 5'd1; readAddr2 = 5'd2; #1;
    chk("pre_rst_x1", readData1, 32'heeeeffff);
    reset = 1'b0; #1;
    chk("rst_ra2",  readRa,    32'h0);
    chk("rst_x1",   readData1, 32'h0);
    chk("rst_sp",   readData2, 32'h0);
    level = 3'd1; readAddr1 = 5'd3; #1;
    chk("rst_ra1",  readRa,    32'h0);
    chk("rst_x3",   readData1, 32'h0);
    // writes during reset are dropped
    writeEn = 1'b1; writeAddr = 5'd3; writeData = 32'h00000077;
    tick(); idle();
    @(negedge clk); reset = 1'b1; #1;
    chk("rst_wr_drop", readData1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
